// File: rtl/row_scan_sequencer_if.sv
// Control/status bundle between a scan master and the row scan sequencer.
// start/stop/mode/skip_mask are level commands sampled on each rising clk edge (no ready);
// every status output is registered and may be sampled at any time away from the edge.
interface row_scan_sequencer_if;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] skip_mask;
  logic       dec_en;
  logic [2:0] dec_sel;
  logic       busy;
  logic       row_strobe;
  logic       sweep_done;
  logic [1:0] state;

  modport master (
    output start, stop, mode, skip_mask,
    input  dec_en, dec_sel, busy, row_strobe, sweep_done, state
  );

  modport slave (
    input  start, stop, mode, skip_mask,
    output dec_en, dec_sel, busy, row_strobe, sweep_done, state
  );
endinterface

// File: rtl/row_scan_sequencer.sv
// Timed row scanner for a 3-to-8 decoder: blanks, then dwells on each unmasked row,
// with single-sweep or continuous operation and abort.
module row_scan_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  row_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD =
    (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  state_t           st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       sel, sel_n;
  logic             en, en_n;
  logic             busy, busy_n;
  logic             strobe, strobe_n;
  logic             done, done_n;
  logic             mode_q, mode_n;

  logic [3:0]       lowest;
  logic [3:0]       above;
  logic             load_row;
  logic [2:0]       row_n;
  logic             go_idle;

  // Returns {found, row}: lowest unmasked row, optionally restricted to rows above 'floor_row'.
  function automatic logic [3:0] first_open(input logic [7:0] mask,
                                            input logic [2:0] floor_row,
                                            input logic       use_floor);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!mask[i] && (!use_floor || (3'(i) > floor_row)))
        r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      cnt    <= '0;
      sel    <= '0;
      en     <= 1'b0;
      busy   <= 1'b0;
      strobe <= 1'b0;
      done   <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      sel    <= sel_n;
      en     <= en_n;
      busy   <= busy_n;
      strobe <= strobe_n;
      done   <= done_n;
      mode_q <= mode_n;
    end
  end

  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    sel_n    = sel;
    en_n     = en;
    busy_n   = busy;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    mode_n   = mode_q;
    load_row = 1'b0;
    row_n    = sel;
    go_idle  = 1'b0;
    lowest   = first_open(bus.skip_mask, 3'd0, 1'b0);
    above    = first_open(bus.skip_mask, sel, 1'b1);

    case (st)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (lowest[3]) begin
            mode_n   = bus.mode;
            load_row = 1'b1;
            row_n    = lowest[2:0];
          end else begin
            done_n = 1'b1;
          end
        end
      end
      BLANK: begin
        if (bus.stop) begin
          go_idle = 1'b1;
        end else if (cnt == '0) begin
          st_n     = DWELL;
          cnt_n    = DWELL_LOAD;
          en_n     = 1'b1;
          strobe_n = 1'b1;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      DWELL: begin
        if (bus.stop) begin
          go_idle = 1'b1;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (!lowest[3]) begin
          // Everything masked at the advance point: the sweep ends regardless of mode.
          done_n  = 1'b1;
          go_idle = 1'b1;
        end else if (above[3]) begin
          load_row = 1'b1;
          row_n    = above[2:0];
        end else begin
          done_n = 1'b1;
          if (mode_q) begin
            go_idle = 1'b1;
          end else begin
            load_row = 1'b1;
            row_n    = lowest[2:0];
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      st_n   = IDLE;
      cnt_n  = '0;
      en_n   = 1'b0;
      busy_n = 1'b0;
    end else if (load_row) begin
      sel_n  = row_n;
      busy_n = 1'b1;
      if (BLANK_CYCLES > 0) begin
        st_n  = BLANK;
        cnt_n = BLANK_LOAD;
        en_n  = 1'b0;
      end else begin
        // No blanking: stay enabled and strobe on the same edge the select changes.
        st_n     = DWELL;
        cnt_n    = DWELL_LOAD;
        en_n     = 1'b1;
        strobe_n = 1'b1;
      end
    end
  end

  assign bus.dec_en     = en;
  assign bus.dec_sel    = sel;
  assign bus.busy       = busy;
  assign bus.row_strobe = strobe;
  assign bus.sweep_done = done;
  assign bus.state      = st;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed bench for row_scan_sequencer: a default-timing instance and a no-blanking instance.
module tb_row_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_row;

  always #5 clk = ~clk;

  row_scan_sequencer_if a_if ();
  row_scan_sequencer_if b_if ();

  row_scan_sequencer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  row_scan_sequencer #(.BLANK_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Status packed as {busy, dec_en, row_strobe, sweep_done, dec_sel}.
  function automatic logic [31:0] pack(input logic b, input logic e, input logic s,
                                       input logic d, input logic [2:0] r);
    return {25'b0, b, e, s, d, r};
  endfunction

  function automatic logic [31:0] snap_a();
    return pack(a_if.busy, a_if.dec_en, a_if.row_strobe, a_if.sweep_done, a_if.dec_sel);
  endfunction

  function automatic logic [31:0] snap_b();
    return pack(b_if.busy, b_if.dec_en, b_if.row_strobe, b_if.sweep_done, b_if.dec_sel);
  endfunction

  initial begin
    a_if.start = 0; a_if.stop = 0; a_if.mode = 0; a_if.skip_mask = 8'h00;
    b_if.start = 0; b_if.stop = 0; b_if.mode = 0; b_if.skip_mask = 8'h00;
    repeat (2) tick();
    check("rst_a_out", snap_a(), 32'h0);
    check("rst_a_state", 32'(a_if.state), 32'h0);
    check("rst_b_out", snap_b(), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_idle", snap_a(), 32'h0);

    // Test 1: full single sweep, 8 rows of 2 blank + 4 dwell.
    a_if.mode = 1; a_if.skip_mask = 8'h00; a_if.start = 1;
    tick();
    a_if.start = 0;
    for (int c = 0; c < 48; c++) begin
      check($sformatf("t1_c%0d", c), snap_a(),
            pack(1'b1, (c % 6) >= 2, (c % 6) == 2, 1'b0, 3'(c / 6)));
      tick();
    end
    check("t1_done", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd7));
    tick();
    check("t1_idle", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd7));

    // Test 2: continuous, odd rows masked; scoreboard of dwell rows.
    for (int k = 0; k < 8; k++) exp_q.push_back(3'((k % 4) * 2));
    a_if.mode = 0; a_if.skip_mask = 8'hAA; a_if.start = 1;
    tick();
    a_if.start = 0;
    for (int c = 0; c < 50; c++) begin
      if (a_if.row_strobe) begin
        check("t2_q_avail", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) begin
          exp_row = exp_q.pop_front();
          check($sformatf("t2_row_c%0d", c), 32'(a_if.dec_sel), 32'(exp_row));
        end
      end
      check($sformatf("t2_done_c%0d", c), 32'(a_if.sweep_done), 32'(c == 24 || c == 48));
      check($sformatf("t2_en_c%0d", c), 32'(a_if.dec_en), 32'((c % 6) >= 2));
      tick();
    end
    check("t2_q_empty", 32'(exp_q.size()), 32'h0);
    a_if.stop = 1;
    tick();
    a_if.stop = 0;
    check("t2_stopped", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));

    // Test 3: stop during row 3, dwell cycle 2; then start+stop together.
    a_if.mode = 1; a_if.skip_mask = 8'h00; a_if.start = 1;
    tick();
    a_if.start = 0;
    repeat (21) tick();
    check("t3_row3_dwell", snap_a(), pack(1'b1, 1'b1, 1'b0, 1'b0, 3'd3));
    a_if.stop = 1;
    tick();
    a_if.stop = 0;
    check("t3_stop", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
    check("t3_stop_state", 32'(a_if.state), 32'h0);
    repeat (3) tick();
    check("t3_stays_idle", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
    a_if.start = 1; a_if.stop = 1;
    tick();
    a_if.start = 0; a_if.stop = 0;
    check("t3_both", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
    tick();
    check("t3_both_after", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));

    // Test 4a: all rows masked at start.
    a_if.skip_mask = 8'hFF; a_if.start = 1;
    tick();
    a_if.start = 0;
    check("t4_ff_done", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd3));
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("t4_ff_quiet%0d", c), snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd3));
    end

    // Test 4b: mask goes to FF during row 1 blanking in continuous mode.
    a_if.mode = 0; a_if.skip_mask = 8'h00; a_if.start = 1;
    tick();
    a_if.start = 0;
    repeat (7) tick();
    a_if.skip_mask = 8'hFF;
    for (int c = 8; c < 12; c++) begin
      tick();
      check($sformatf("t4_row1_c%0d", c), snap_a(), pack(1'b1, 1'b1, c == 8, 1'b0, 3'd1));
    end
    tick();
    check("t4_mid_ff_done", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd1));
    tick();
    check("t4_mid_ff_idle", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd1));
    a_if.skip_mask = 8'h00;

    // Test 5: asynchronous reset between edges while dwelling on row 1.
    a_if.mode = 1; a_if.start = 1;
    tick();
    a_if.start = 0;
    repeat (9) tick();
    check("t5_pre_rst", snap_a(), pack(1'b1, 1'b1, 1'b0, 1'b0, 3'd1));
    #2 rst = 1'b1;
    #1;
    check("t5_async_rst", snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("t5_idle%0d", c), snap_a(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    end

    // Test 6: no-blanking build, single sweep.
    b_if.mode = 1; b_if.skip_mask = 8'h00; b_if.start = 1;
    tick();
    b_if.start = 0;
    for (int c = 0; c < 32; c++) begin
      check($sformatf("t6_c%0d", c), snap_b(),
            pack(1'b1, 1'b1, (c % 4) == 0, 1'b0, 3'(c / 4)));
      tick();
    end
    check("t6_done", snap_b(), pack(1'b0, 1'b0, 1'b0, 1'b1, 3'd7));
    tick();
    check("t6_idle", snap_b(), pack(1'b0, 1'b0, 1'b0, 1'b0, 3'd7));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
